bcd_mod_counter: RTL and testbench
==================================

# bcd_mod_counter

Parametrised N-digit BCD modulo counter, the generic successor of the fixed minute counter: one instance per clock field (seconds, minutes, hours, day, month, year digits). Counts MIN_VALUE..max with wrap, zero-latency carry for cascading into the next field, and manual up/down adjust with hold-to-repeat auto-stepping. Supports a runtime maximum (days-in-month), synchronous load with range checking, and correct down-wrap.

## Interface
- DIGITS, 2, number of BCD digits; value width W = 4*DIGITS
- MIN_VALUE, 0, lowest count, decimal (1 for day/month)
- MAX_VALUE, 59, highest count, decimal; must be < 10^DIGITS
- DYN_MAX, 0, 1 = use max_val port instead of MAX_VALUE
- REPEAT_DELAY, 8, tick pulses a button is held before auto-repeat starts (≥1)
- REPEAT_RATE, 2, tick pulses between auto-repeat steps (≥1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run step: +1 this cycle (carry from lower field)
- up  in  1  adjust increment button, level, synchronised upstream
- down  in  1  adjust decrement button, level, synchronised upstream
- tick  in  1  one-cycle timebase strobe for auto-repeat
- load  in  1  synchronous load of load_val
- load_val  in  W  BCD value to load
- max_val  in  W  BCD runtime maximum (DYN_MAX=1 only)
- value  out  W  current count, BCD, digit 0 = LSD
- carry  out  1  combinational: en & (value == max)
- load_err  out  1  one-cycle pulse: rejected load

## Operation
- max = DYN_MAX ? max_val : MAX_VALUE (BCD). Wrap = max → MIN_VALUE up, MIN_VALUE → max down.
- Per-cycle priority: load > en > clamp > adjust step.
- load: load_val accepted if every digit ≤ 9 and MIN_VALUE ≤ load_val ≤ max; else value ← MIN_VALUE and load_err = 1 next cycle.
- en: value ← value+1 in BCD (digit ripple, digit 9 → 0 with carry into next digit); value == max → MIN_VALUE.
- Clamp (DYN_MAX=1): value > max with no load/en → value ← max (day 31 with month change to 30 → 30).
- Adjust FSM, states IDLE, HOLD, REPEAT; dir latched at entry:
  - IDLE: up & !down rising → step +1, dir=UP, HOLD, cnt=0. down & !up rising → step −1, dir=DN, HOLD.
  - HOLD: each tick cnt++; cnt reaches REPEAT_DELAY → step, REPEAT, cnt=0.
  - REPEAT: each tick cnt++; cnt reaches REPEAT_RATE → step, cnt=0.
  - HOLD/REPEAT: latched button released, or both buttons high → IDLE, no step.
- Adjust steps wrap in both directions and never assert carry (no ripple into the higher field).
- An adjust step coinciding with load or en is dropped; FSM still advances.

## Timing
- Reset: value = MIN_VALUE in BCD, carry = 0 (en low), load_err = 0, FSM IDLE, cnt = 0, edge-detect registers 0.
- load, en, adjust step: value updates on the next clk edge (1 cycle).
- carry is same-cycle combinational, for wiring to the higher field's en; a chain of N fields rolls over in one edge.
- First adjust step: edge after the button rising edge. Repeat: REPEAT_DELAY ticks after, then every REPEAT_RATE ticks.
- rst_n asserted mid-hold: FSM IDLE; a still-held button after release of reset is not a rising edge (edge registers reset to 0, so held button steps once only if it was low at reset—decided: edge register resets to 0, button held through reset produces one step).

## Structure
- Shared package clock_pkg: BCD digit type, function bcd_to_int/int_to_bcd for parameter conversion, adjust FSM state enum.
- Sub-module bcd_incdec: combinational W-bit BCD ±1 with wrap bounds (min, max); instantiated once, direction selected by priority logic.

## Test plan
- DIGITS=2, 0..59: en held 60 cycles from 00 → 01..59, 00; carry high only in the cycle value=59.
- down edge at 00 → 59; at 10 → 09; at 50 → 49 (tens borrow correct).
- up held, REPEAT_DELAY=8, REPEAT_RATE=2, tick every 4 clk: steps at clk 1, 33, 41, 49…; release → IDLE, no further step; up+down together → no step.
- Month config MIN=1 MAX=12: load 0x13 → value 01, load_err pulse; load 0x12 then en → 01, carry high during 12.
- DYN_MAX=1, value 31, max_val 31→30 → value 30 next cycle; max_val 28, value 28, en → 01.
- rst_n low mid-REPEAT with value 37 → value 00, FSM IDLE, carry 0 immediately (async).

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock field counters: BCD digit type,
// adjust-FSM state encoding and parameter-time BCD/integer conversion.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ADJ_IDLE   = 2'd0,
        ADJ_HOLD   = 2'd1,
        ADJ_REPEAT = 2'd2
    } adj_state_t;

    localparam int         MAX_DIGITS = 8;
    localparam bcd_digit_t BCD_NINE   = 4'd9;
    localparam logic       DIR_UP     = 1'b0;
    localparam logic       DIR_DN     = 1'b1;

    // Conversions cover up to MAX_DIGITS digits; callers slice what they need.
    function automatic logic [31:0] int_to_bcd(input int val);
        logic [31:0] res;
        int          v;
        res = '0;
        v   = val;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            res[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return res;
    endfunction

    function automatic int bcd_to_int(input logic [31:0] bcd);
        int res;
        res = 0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            res = res * 10 + int'(bcd[4*i +: 4]);
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_mod_counter_incdec.sv
// Combinational N-digit BCD +1 / -1 with wrap between min_val and max_val.
module bcd_incdec
    import clock_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] value,
    input  logic                down,
    input  logic [4*DIGITS-1:0] min_val,
    input  logic [4*DIGITS-1:0] max_val,
    output logic [4*DIGITS-1:0] result
);

    logic       ripple;
    bcd_digit_t digit;

    // Valid BCD orders the same as its raw bits, so bound tests use plain compares.
    always_comb begin
        result = value;
        ripple = 1'b1;
        digit  = '0;
        if (down == DIR_UP) begin
            if (value >= max_val) begin
                result = min_val;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    digit = value[4*i +: 4];
                    if (ripple) begin
                        if (digit >= BCD_NINE) begin
                            result[4*i +: 4] = 4'd0;
                        end else begin
                            result[4*i +: 4] = digit + 4'd1;
                            ripple = 1'b0;
                        end
                    end
                end
            end
        end else begin
            if (value <= min_val) begin
                result = max_val;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    digit = value[4*i +: 4];
                    if (ripple) begin
                        if (digit == 4'd0) begin
                            result[4*i +: 4] = BCD_NINE;
                        end else begin
                            result[4*i +: 4] = digit - 4'd1;
                            ripple = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// One clock field: BCD modulo counter with cascade carry, checked load,
// runtime maximum clamp and button adjust with hold-to-repeat.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int DIGITS       = 2,
    parameter int MIN_VALUE    = 0,
    parameter int MAX_VALUE    = 59,
    parameter int DYN_MAX      = 0,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up,
    input  logic                down,
    input  logic                tick,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic [4*DIGITS-1:0] max_val,
    output logic [4*DIGITS-1:0] value,
    output logic                carry,
    output logic                load_err
);

    localparam int          W         = 4 * DIGITS;
    localparam logic [31:0] MIN_BCD32 = int_to_bcd(MIN_VALUE);
    localparam logic [31:0] MAX_BCD32 = int_to_bcd(MAX_VALUE);
    localparam logic [W-1:0] MIN_BCD  = MIN_BCD32[W-1:0];
    localparam logic [W-1:0] MAX_BCD  = MAX_BCD32[W-1:0];
    localparam int          CNT_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int          CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_CNT  = CNT_W'(REPEAT_RATE);

    logic [W-1:0]     value_q;
    logic [W-1:0]     value_d;
    logic [W-1:0]     max_bcd;
    logic [W-1:0]     step_result;
    logic             step_down;
    logic             load_digits_ok;
    logic             load_ok;
    logic             load_err_d;
    logic             unused_max;

    adj_state_t       state_q;
    adj_state_t       state_d;
    logic             dir_q;
    logic             dir_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             up_q;
    logic             down_q;
    logic             up_rise;
    logic             down_rise;
    logic             held;
    logic             adj_step;
    logic             adj_down;

    // max_val only matters for the day field; other instances leave it dangling.
    assign unused_max = ^max_val;
    assign max_bcd    = (DYN_MAX != 0) ? max_val : MAX_BCD;

    assign value = value_q;
    assign carry = en & (value_q == max_bcd);

    always_comb begin
        load_digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > BCD_NINE) begin
                load_digits_ok = 1'b0;
            end
        end
    end

    assign load_ok = load_digits_ok && (load_val >= MIN_BCD) && (load_val <= max_bcd);

    // A run step always counts up; otherwise the shared incdec follows the adjust direction.
    assign step_down = en ? DIR_UP : adj_down;

    bcd_incdec #(
        .DIGITS (DIGITS)
    ) u_incdec (
        .value   (value_q),
        .down    (step_down),
        .min_val (MIN_BCD),
        .max_val (max_bcd),
        .result  (step_result)
    );

    always_comb begin
        value_d    = value_q;
        load_err_d = 1'b0;
        if (load) begin
            value_d    = load_ok ? load_val : MIN_BCD;
            load_err_d = !load_ok;
        end else if (en) begin
            value_d = step_result;
        end else if ((DYN_MAX != 0) && (value_q > max_bcd)) begin
            value_d = max_bcd;
        end else if (adj_step) begin
            value_d = step_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= MIN_BCD;
            load_err <= 1'b0;
        end else begin
            value_q  <= value_d;
            load_err <= load_err_d;
        end
    end

    assign up_rise   = up & ~up_q;
    assign down_rise = down & ~down_q;
    assign held      = (dir_q == DIR_DN) ? down : up;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Adjust FSM: the step request is computed even when load/en will override it.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        adj_step = 1'b0;
        adj_down = dir_q;
        case (state_q)
            ADJ_IDLE: begin
                cnt_d = '0;
                if (up_rise && !down) begin
                    adj_step = 1'b1;
                    adj_down = DIR_UP;
                    dir_d    = DIR_UP;
                    state_d  = ADJ_HOLD;
                end else if (down_rise && !up) begin
                    adj_step = 1'b1;
                    adj_down = DIR_DN;
                    dir_d    = DIR_DN;
                    state_d  = ADJ_HOLD;
                end
            end
            ADJ_HOLD, ADJ_REPEAT: begin
                if (!held || (up && down)) begin
                    state_d = ADJ_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_inc == ((state_q == ADJ_HOLD) ? DELAY_CNT : RATE_CNT)) begin
                        adj_step = 1'b1;
                        state_d  = ADJ_REPEAT;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ADJ_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ADJ_IDLE;
            dir_q   <= DIR_UP;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            up_q    <= up;
            down_q  <= down;
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: seconds (0..59), month (1..12)
// and dynamic-max day (1..max_val) instances checked against an integer model.
module tb_bcd_mod_counter;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_i[NI];
    logic       up_i[NI];
    logic       down_i[NI];
    logic       tick_i[NI];
    logic       load_i[NI];
    logic [7:0] load_val_i[NI];
    logic [7:0] max_val_i[NI];
    logic [7:0] value_o[NI];
    logic       carry_o[NI];
    logic       load_err_o[NI];

    int mn[NI]  = '{0, 1, 1};
    int mx[NI]  = '{59, 12, 31};
    bit dyn[NI] = '{1'b0, 1'b0, 1'b1};

    typedef struct {
        int val;
        int state;
        int dir;
        int cnt;
        bit up_q;
        bit down_q;
    } model_t;

    typedef struct {
        int inst;
        int val;
        bit lerr;
    } exp_t;

    model_t mdl[NI];
    exp_t   sb[$];
    bit     last_carry[NI];
    int     n_checks;
    int     n_fail;

    always #5 clk = ~clk;

    bcd_mod_counter #(.DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(59), .DYN_MAX(0),
                      .REPEAT_DELAY(8), .REPEAT_RATE(2)) dut_sec (
        .clk(clk), .rst_n(rst_n), .en(en_i[0]), .up(up_i[0]), .down(down_i[0]),
        .tick(tick_i[0]), .load(load_i[0]), .load_val(load_val_i[0]), .max_val(max_val_i[0]),
        .value(value_o[0]), .carry(carry_o[0]), .load_err(load_err_o[0]));

    bcd_mod_counter #(.DIGITS(2), .MIN_VALUE(1), .MAX_VALUE(12), .DYN_MAX(0),
                      .REPEAT_DELAY(8), .REPEAT_RATE(2)) dut_mon (
        .clk(clk), .rst_n(rst_n), .en(en_i[1]), .up(up_i[1]), .down(down_i[1]),
        .tick(tick_i[1]), .load(load_i[1]), .load_val(load_val_i[1]), .max_val(max_val_i[1]),
        .value(value_o[1]), .carry(carry_o[1]), .load_err(load_err_o[1]));

    bcd_mod_counter #(.DIGITS(2), .MIN_VALUE(1), .MAX_VALUE(31), .DYN_MAX(1),
                      .REPEAT_DELAY(8), .REPEAT_RATE(2)) dut_day (
        .clk(clk), .rst_n(rst_n), .en(en_i[2]), .up(up_i[2]), .down(down_i[2]),
        .tick(tick_i[2]), .load(load_i[2]), .load_val(load_val_i[2]), .max_val(max_val_i[2]),
        .value(value_o[2]), .carry(carry_o[2]), .load_err(load_err_o[2]));

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_valid(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic int cur_max(input int i);
        return dyn[i] ? from_bcd(max_val_i[i]) : mx[i];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mdl[i] = '{val: mn[i], state: 0, dir: 0, cnt: 0, up_q: 1'b0, down_q: 1'b0};
        end
        sb.delete();
    endtask

    // Integer reference: one clock edge of field i given its current inputs.
    task automatic model_step(input int i);
        model_t m;
        exp_t   e;
        int     mxv;
        int     lv;
        bit     ur, dr, stp, sdn, ok;
        m   = mdl[i];
        mxv = cur_max(i);
        ur  = up_i[i] && !m.up_q;
        dr  = down_i[i] && !m.down_q;
        stp = 1'b0;
        sdn = 1'b0;
        if (m.state == 0) begin
            if (ur && !down_i[i]) begin
                stp = 1'b1; sdn = 1'b0; m.dir = 0; m.state = 1; m.cnt = 0;
            end else if (dr && !up_i[i]) begin
                stp = 1'b1; sdn = 1'b1; m.dir = 1; m.state = 1; m.cnt = 0;
            end
        end else begin
            if (!(m.dir == 1 ? down_i[i] : up_i[i]) || (up_i[i] && down_i[i])) begin
                m.state = 0; m.cnt = 0;
            end else if (tick_i[i]) begin
                m.cnt++;
                if (m.cnt == ((m.state == 1) ? 8 : 2)) begin
                    stp = 1'b1; sdn = (m.dir == 1); m.state = 2; m.cnt = 0;
                end
            end
        end
        m.up_q   = up_i[i];
        m.down_q = down_i[i];
        e.inst   = i;
        e.lerr   = 1'b0;
        if (load_i[i]) begin
            lv = from_bcd(load_val_i[i]);
            ok = bcd_valid(load_val_i[i]) && (lv >= mn[i]) && (lv <= mxv);
            m.val  = ok ? lv : mn[i];
            e.lerr = !ok;
        end else if (en_i[i]) begin
            m.val = (m.val >= mxv) ? mn[i] : m.val + 1;
        end else if (dyn[i] && (m.val > mxv)) begin
            m.val = mxv;
        end else if (stp) begin
            if (sdn) m.val = (m.val <= mn[i]) ? mxv : m.val - 1;
            else     m.val = (m.val >= mxv) ? mn[i] : m.val + 1;
        end
        e.val  = m.val;
        mdl[i] = m;
        sb.push_back(e);
    endtask

    // Called at a negedge with inputs set; returns at the following negedge.
    task automatic applyStimulus();
        exp_t e;
        #1;
        for (int i = 0; i < NI; i++) begin
            last_carry[i] = carry_o[i];
            checkOutput($sformatf("carry[%0d]", i), 32'(carry_o[i]),
                        32'(en_i[i] && (mdl[i].val == cur_max(i))));
            model_step(i);
        end
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput($sformatf("value[%0d]", e.inst), 32'(value_o[e.inst]), 32'(to_bcd(e.val)));
            checkOutput($sformatf("load_err[%0d]", e.inst), 32'(load_err_o[e.inst]), 32'(e.lerr));
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            en_i[i]   = 1'b0;
            up_i[i]   = 1'b0;
            down_i[i] = 1'b0;
            tick_i[i] = 1'b0;
            load_i[i] = 1'b0;
            load_val_i[i] = 8'h00;
        end
        max_val_i[0] = 8'h00;
        max_val_i[1] = 8'h00;
    endtask

    task automatic load_field(input int i, input logic [7:0] v);
        load_i[i] = 1'b1;
        load_val_i[i] = v;
        applyStimulus();
        load_i[i] = 1'b0;
    endtask

    task automatic pulse_down(input int i);
        down_i[i] = 1'b1;
        applyStimulus();
        down_i[i] = 1'b0;
        applyStimulus();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int carry_cnt;
        int steps[$];
        int exp_steps[4] = '{1, 33, 41, 49};
        logic [7:0] prev;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        max_val_i[2] = 8'h31;
        model_reset();

        #12;
        checkOutput("rst_sec_value", 32'(value_o[0]), 32'h00);
        checkOutput("rst_mon_value", 32'(value_o[1]), 32'h01);
        checkOutput("rst_day_value", 32'(value_o[2]), 32'h01);
        checkOutput("rst_carry", 32'(carry_o[0]), 32'h0);
        checkOutput("rst_load_err", 32'(load_err_o[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] seconds: 60 run steps");
        en_i[0] = 1'b1;
        carry_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            applyStimulus();
            if (last_carry[0]) carry_cnt++;
        end
        en_i[0] = 1'b0;
        checkOutput("sec_carry_count", 32'(carry_cnt), 32'd1);
        checkOutput("sec_after_60", 32'(value_o[0]), 32'h00);

        $display("[TB] seconds: down wrap and borrow");
        pulse_down(0);
        checkOutput("down_wrap_00", 32'(value_o[0]), 32'h59);
        load_field(0, 8'h10);
        pulse_down(0);
        checkOutput("down_borrow_10", 32'(value_o[0]), 32'h09);
        load_field(0, 8'h50);
        pulse_down(0);
        checkOutput("down_borrow_50", 32'(value_o[0]), 32'h49);

        $display("[TB] seconds: hold-to-repeat");
        load_field(0, 8'h00);
        up_i[0] = 1'b1;
        for (int c = 0; c <= 50; c++) begin
            tick_i[0] = (c % 4 == 0) && (c > 0);
            prev = value_o[0];
            applyStimulus();
            if (value_o[0] != prev) steps.push_back(c + 1);
        end
        checkOutput("repeat_step_count", 32'(steps.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("repeat_step_%0d", k),
                        32'((k < steps.size()) ? steps[k] : -1), 32'(exp_steps[k]));
        end
        up_i[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick_i[0] = (c % 4 == 0);
            applyStimulus();
        end
        checkOutput("release_no_step", 32'(value_o[0]), 32'h04);
        up_i[0]   = 1'b1;
        down_i[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick_i[0] = (c % 2 == 0);
            applyStimulus();
        end
        checkOutput("both_no_step", 32'(value_o[0]), 32'h04);
        up_i[0]   = 1'b0;
        down_i[0] = 1'b0;
        tick_i[0] = 1'b0;
        applyStimulus();

        $display("[TB] seconds: reset during repeat");
        load_field(0, 8'h37);
        up_i[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick_i[0] = (c % 4 == 0) && (c > 0);
            applyStimulus();
        end
        tick_i[0] = 1'b0;
        en_i[0]   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_value", 32'(value_o[0]), 32'h00);
        checkOutput("async_rst_carry", 32'(carry_o[0]), 32'h0);
        en_i[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        applyStimulus();
        checkOutput("held_through_rst", 32'(value_o[0]), 32'h01);
        up_i[0] = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("held_once_only", 32'(value_o[0]), 32'h01);

        $display("[TB] month: load range check");
        load_field(1, 8'h13);
        checkOutput("mon_load13_value", 32'(value_o[1]), 32'h01);
        checkOutput("mon_load13_err", 32'(load_err_o[1]), 32'h1);
        applyStimulus();
        checkOutput("mon_err_one_cycle", 32'(load_err_o[1]), 32'h0);
        load_field(1, 8'h12);
        en_i[1] = 1'b1;
        applyStimulus();
        en_i[1] = 1'b0;
        checkOutput("mon_carry_at_12", 32'(last_carry[1]), 32'h1);
        checkOutput("mon_wrap_to_01", 32'(value_o[1]), 32'h01);
        load_field(1, 8'h1A);
        checkOutput("mon_bad_digit_err", 32'(load_err_o[1]), 32'h1);
        load_field(1, 8'h00);
        checkOutput("mon_below_min_err", 32'(load_err_o[1]), 32'h1);
        load_field(1, 8'h07);
        pulse_down(1);
        checkOutput("mon_down_07", 32'(value_o[1]), 32'h06);

        $display("[TB] day: runtime maximum");
        load_field(2, 8'h31);
        checkOutput("day_load31", 32'(value_o[2]), 32'h31);
        max_val_i[2] = 8'h30;
        applyStimulus();
        checkOutput("day_clamp_30", 32'(value_o[2]), 32'h30);
        max_val_i[2] = 8'h28;
        load_field(2, 8'h28);
        en_i[2] = 1'b1;
        applyStimulus();
        en_i[2] = 1'b0;
        checkOutput("day_carry_at_28", 32'(last_carry[2]), 32'h1);
        checkOutput("day_wrap_01", 32'(value_o[2]), 32'h01);
        pulse_down(2);
        checkOutput("day_down_wrap_28", 32'(value_o[2]), 32'h28);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
